// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, mode encoding {cpol,cpha}
// and the rule that picks which sclk edge samples mosi.
package spi_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin into the pclk domain.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      stg <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: synchronizes sclk/ss/mosi into pclk, shifts one
// DATA_W frame per transfer with a single-entry transmit buffer.
module spi_slave_shift
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [SET_W-1:0] SET_DONE = SET_W'(SYNC_STAGES + 1);

  // sclk is synchronized relative to cpol, so an all-zero flop chain is the idle level.
  logic sclk_rel_s, ss_s, mosi_s;
  logic sclk_rel_d, ss_d;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .pclk(pclk), .preset_n(preset_n), .d(sclk ^ cpol), .q(sclk_rel_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .pclk(pclk), .preset_n(preset_n), .d(ss), .q(ss_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .pclk(pclk), .preset_n(preset_n), .d(mosi), .q(mosi_s));

  logic [SET_W-1:0]  settle;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, tx_buf, rx_shift;
  logic              buf_full;

  logic              samp_rise, sclk_rise, sclk_fall, active;
  logic              sample_edge, shift_edge, ss_fall, ss_rise;
  logic              frame_done, load, present;
  logic [DATA_W-1:0] load_word, tx_word, rx_next;

  assign samp_rise   = sample_on_rise(spi_mode_e'({cpol, cpha}));
  assign sclk_rise   = ~(sclk_rel_d ^ cpol) &  (sclk_rel_s ^ cpol);
  assign sclk_fall   =  (sclk_rel_d ^ cpol) & ~(sclk_rel_s ^ cpol);
  // armed keeps a reset released mid-frame from treating the still-low ss as a new frame.
  assign active      = armed & ~ss_s;
  assign sample_edge = active & (samp_rise ? sclk_rise : sclk_fall);
  assign shift_edge  = active & (samp_rise ? sclk_fall : sclk_rise);
  assign ss_fall     = armed & ss_d & ~ss_s;
  assign ss_rise     = ~ss_d & ss_s;
  assign frame_done  = (bit_cnt == CNT_FULL);
  assign load        = ss_fall | (shift_edge & frame_done);
  assign present     = shift_edge | (load & ~cpha);
  assign load_word   = buf_full ? tx_buf : '0;
  assign tx_word     = load ? load_word : tx_shift;
  assign rx_next     = lsbfe ? {mosi_s, rx_shift[DATA_W-1:1]}
                             : {rx_shift[DATA_W-2:0], mosi_s};
  assign tx_ready    = ~buf_full;
  assign miso_oe     = ~ss_s;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sclk_rel_d  <= 1'b0;
      ss_d        <= 1'b1;
      settle      <= '0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      miso        <= 1'b0;
    end else begin
      sclk_rel_d  <= sclk_rel_s;
      ss_d        <= ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (settle != SET_DONE) settle <= settle + 1'b1;
      else if (ss_s)          armed  <= 1'b1;

      // A write landing with an underrun load is kept for the next frame.
      if (load) begin
        if (!buf_full) tx_underrun <= 1'b1;
        buf_full <= 1'b0;
      end
      if (tx_valid && !buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end

      if (present) begin
        miso     <= lsbfe ? tx_word[0] : tx_word[DATA_W-1];
        tx_shift <= lsbfe ? (tx_word >> 1) : (tx_word << 1);
      end else if (load) begin
        tx_shift <= tx_word;
      end

      if (ss_rise) begin
        bit_cnt <= '0;
        if (bit_cnt != '0 && bit_cnt < CNT_FULL) begin
          frame_abort <= 1'b1;
          rx_shift    <= '0;
          tx_shift    <= '0;
        end
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
        if (bit_cnt == CNT_LAST) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end else if (load) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule
